led_blinker_multi: RTL

LED_BLINKER_MULTI -- requirements
Module: led_blinker_multi

---
 rtl/led_blinker_multi.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/led_blinker_multi.sv
// led_blinker_multi: N_CH LED channels driven from four shared rate timers.
// Each channel is off, solid on, blinking at one of four rates, or running a
// counted burst of on-pulses at a rate latched when the burst starts.
// Optional feature: define LED_BLINKER_MULTI_DBG_EN to add the o_dbg_tick port
// (registered copy of the four rate ticks).
module led_blinker_multi #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned C0   = 125000,
    parameter int unsigned C1   = 250000,
    parameter int unsigned C2   = 1250000,
    parameter int unsigned C3   = 12500000,
    parameter int unsigned BL_W = 4
) (
    input  logic                i_clock,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [2*N_CH-1:0]   i_sel,
    input  logic [2*N_CH-1:0]   i_mode,
    input  logic [BL_W-1:0]     i_burst_len,
    input  logic [N_CH-1:0]     i_burst_start,
    output logic [N_CH-1:0]     o_led_drive,
    output logic [N_CH-1:0]     o_burst_busy
`ifdef LED_BLINKER_MULTI_DBG_EN
    ,
    output logic [3:0]          o_dbg_tick
`endif
);

    // Counter width covers the slowest (largest) half-period; C0..C2 <= C3.
    localparam int unsigned CW = (C3 > 1) ? $clog2(C3) : 1;

    // Terminal count per rate: counter k wraps after reaching Ck-1.
    localparam logic [3:0][CW-1:0] LIM = {CW'(C3 - 1), CW'(C2 - 1),
                                          CW'(C1 - 1), CW'(C0 - 1)};

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        B_IDLE = 2'b00,
        B_WAIT = 2'b01,
        B_ON   = 2'b10,
        B_OFF  = 2'b11
    } burst_state_e;

    // Shared rate timers
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         phase_q, phase_d;
    logic [3:0]         tick;

    // Per-channel burst state and latched burst parameters
    burst_state_e            state_q [N_CH];
    burst_state_e            state_d [N_CH];
    logic [N_CH-1:0][1:0]    bsel_q, bsel_d;
    logic [N_CH-1:0][BL_W-1:0] rem_q, rem_d;

    // Registered outputs
    logic [N_CH-1:0] led_q, led_d;
    logic [N_CH-1:0] busy_q, busy_d;

    // Rate timers: count while enabled, tick on terminal count, phase toggles
    // the cycle after each tick; disabling clears everything.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tick    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            tick[k] = i_enable && (cnt_q[k] == LIM[k]);
            if (!i_enable || tick[k]) begin
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
            if (!i_enable) begin
                phase_d[k] = 1'b0;
            end else if (tick[k]) begin
                phase_d[k] = ~phase_q[k];
            end
        end
    end

    // Rate timer registers
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Per-channel burst FSM next state and LED/busy output selection.
    // Outputs are derived from the next state so the registered LED is high
    // exactly while the registered state is ON.
    always_comb begin
        state_d = state_q;
        bsel_d  = bsel_q;
        rem_d   = rem_q;
        led_d   = '0;
        busy_d  = '0;
        for (int unsigned n = 0; n < N_CH; n++) begin
            if (!i_enable || (mode_e'(i_mode[2*n +: 2]) != MODE_BURST)) begin
                state_d[n] = B_IDLE;
            end else begin
                unique case (state_q[n])
                    B_IDLE: begin
                        if (i_burst_start[n] && (i_burst_len != '0)) begin
                            state_d[n] = B_WAIT;
                            bsel_d[n]  = i_sel[2*n +: 2];
                            rem_d[n]   = i_burst_len;
                        end
                    end
                    B_WAIT: begin
                        if (tick[bsel_q[n]]) begin
                            state_d[n] = B_ON;
                        end
                    end
                    B_ON: begin
                        if (tick[bsel_q[n]]) begin
                            state_d[n] = B_OFF;
                            rem_d[n]   = rem_q[n] - BL_W'(1);
                        end
                    end
                    B_OFF: begin
                        if (tick[bsel_q[n]]) begin
                            state_d[n] = (rem_q[n] == '0) ? B_IDLE : B_ON;
                        end
                    end
                    default: state_d[n] = B_IDLE;
                endcase
            end

            if (i_enable) begin
                unique case (mode_e'(i_mode[2*n +: 2]))
                    MODE_OFF:   led_d[n] = 1'b0;
                    MODE_ON:    led_d[n] = 1'b1;
                    MODE_BLINK: led_d[n] = phase_q[i_sel[2*n +: 2]];
                    MODE_BURST: led_d[n] = (state_d[n] == B_ON);
                    default:    led_d[n] = 1'b0;
                endcase
            end
            busy_d[n] = (state_d[n] != B_IDLE);
        end
    end

    // Burst FSM state and latched burst parameter registers
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned n = 0; n < N_CH; n++) begin
                state_q[n] <= B_IDLE;
            end
            bsel_q <= '0;
            rem_q  <= '0;
        end else begin
            for (int unsigned n = 0; n < N_CH; n++) begin
                state_q[n] <= state_d[n];
            end
            bsel_q <= bsel_d;
            rem_q  <= rem_d;
        end
    end

    // Output registers
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            led_q  <= '0;
            busy_q <= '0;
        end else begin
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end

    assign o_led_drive  = led_q;
    assign o_burst_busy = busy_q;

`ifdef LED_BLINKER_MULTI_DBG_EN
    logic [3:0] dbg_tick_q, dbg_tick_d;

    // Debug tick capture: one-cycle registered copy of each rate tick
    always_comb begin
        dbg_tick_d = tick;
    end

    // Debug tick register
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbg_tick_q <= '0;
        end else begin
            dbg_tick_q <= dbg_tick_d;
        end
    end

    assign o_dbg_tick = dbg_tick_q;
`endif

endmodule
